reimu_shot_ctrl: RTL and testbench
==================================

Name: reimu_shot_ctrl

Overview:
Player-shot scheduler for the player sprite. It owns a fixed pool of shot slots and decides when a new shot may be launched from the current player position, allocating the lowest-index free slot. Each tick it advances live shots upward and retires them at the top of the play field or on collision. It sits between the player position block and the renderer/collision logic, and runs on the frame-rate clock.

Parameters:
NSHOT, 4, number of shot slots (1..8)
COOLDOWN, 6, ticks of mandatory gap after a launch (0 = fire every tick)
SHOT_SPEED, 10, pixels a shot moves up per tick
SHOT_YOFF, 10, launch offset above player y
Y_TOP, 10, retire threshold (top of play field)

Ports:
clk22  in  1  frame-rate clock; every rising edge is one tick
rst  in  1  synchronous, active-low reset
gameover  in  1  level-sensitive synchronous clear, same effect as reset
fire  in  1  fire button level; held = auto-fire
reimux  in  10  current player x
reimuy  in  10  current player y
hit  in  NSHOT  per-slot kill from collision logic, sampled each tick
shot_valid  out  NSHOT  slot i live
shot_x  out  10*NSHOT  slot i x at bits [10i+9:10i]
shot_y  out  10*NSHOT  slot i y at bits [10i+9:10i]
fire_ack  out  1  one-tick pulse on the tick a shot launches
cool_busy  out  1  high while the cooldown counter is nonzero

Behaviour:
- Reset/gameover (rst==0 or gameover==1 at edge): shot_valid=0, all shot_x/shot_y=0, cooldown counter=0, fire_ack=0, FSM=READY. These take priority over every other event.
- FSM: READY (counter==0), COOL (counter>0).
  - READY to COOL on a launch when COOLDOWN>0. If COOLDOWN==0, the FSM stays in READY.
  - COOL counts down by 1 per tick and returns to READY on the tick the counter reaches 0.
  - cool_busy = (state==COOL).
- Per-slot update each tick, for a live slot, in priority order:
  1. hit[i]=1: slot freed (valid cleared, coordinates held).
  2. Else if shot_y < Y_TOP+SHOT_SPEED: slot freed (no wrap below 0).
  3. Else shot_y -= SHOT_SPEED; shot_x is unchanged.
  - hit[i] on a non-live slot is ignored.
- Launch condition:
  - fire=1, state READY, and at least one slot has shot_valid=0 at the start of the tick.
  - Slots freed during the same tick are not reusable until the next tick.
- Launch action:
  - Select the lowest-index free slot k.
  - shot_valid[k]=1; shot_x[k]=reimux; shot_y[k]=reimuy-SHOT_YOFF, saturating at 0 if reimuy<SHOT_YOFF.
  - Load the counter with COOLDOWN; fire_ack=1 for exactly that tick.
  - A newly launched shot does not move on its launch tick.
- Pool full (all valid) with fire=1 in READY:
  - No launch, fire_ack=0, counter stays 0.
  - Launch occurs on the first tick after a slot frees.
- Fire held: one launch every COOLDOWN+1 ticks while slots are available. Fire released in COOL: counting continues regardless.
- Timing: all outputs are registered. Launch is visible on outputs one edge after the sampling edge.
- Inputs reimux/reimuy are used as sampled; range clamping is the position block's job.

Decomposition:
- Shared game package: coordinate width (10), play-field bounds (Y_TOP, screen limits), slot-index width function, FSM state encoding READY/COOL.
- One natural sub-module: shot_slot_alloc. It is a combinational find-first-zero on shot_valid, producing a free flag and slot index k.

Test Plan:
- Reset: rst=0 for 2 ticks with fire=1. Expect shot_valid=0, fire_ack=0, cool_busy=0. After rst=1 with reimux=220 and reimuy=360: slot0 launches with x=220, y=350, fire_ack pulses once.
- Auto-fire, COOLDOWN=6, fire held: launches on ticks 0, 7, 14, 21 into slots 0, 1, 2, 3. Slot0 y on tick 7 = 280.
- Pool full: all 4 slots live and fire held. No fire_ack until a slot retires. The next launch goes into the freed index, one tick after the retire.
- Top retire: a shot launched at y=30 goes to 20 and stays valid. On the next tick, 20<20 is false, so y becomes 10. On the following tick, 10<20, so the slot is freed.
- Hit vs move: hit[1]=1 while slot1 is at y=100. Slot1 is freed that tick. A simultaneous fire with slots 0 and 1 both occupied does not reuse slot1 until the next tick.
- gameover=1 mid-COOL with 3 live shots: next tick all outputs are 0 and the state is READY. With fire=1 after gameover drops, a launch occurs immediately.

Source files
------------

// File: rtl/reimu_shot_ctrl_pkg.sv
// Shared game definitions: coordinate width, play-field bounds, cooldown FSM states.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package reimu_shot_ctrl_pkg;

    localparam int COORD_W   = 10;
    localparam int Y_TOP_DEF = 10;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        READY = 1'b0,
        COOL  = 1'b1
    } cool_state_t;

    // Width of an index able to address n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reimu_shot_ctrl_if.sv
// Player-side controls in, shot pool state out, for the shot scheduler.
// Latency: wires only; all outputs are registered inside the scheduler.
// Backpressure: none; fire is a level and is simply ignored while not allowed.
interface reimu_shot_ctrl_if
    import reimu_shot_ctrl_pkg::*;
#(
    parameter int NSHOT = 4
);
    logic                     gameover;
    logic                     fire;
    coord_t                   reimux;
    coord_t                   reimuy;
    logic [NSHOT-1:0]         hit;
    logic [NSHOT-1:0]         shot_valid;
    logic [COORD_W*NSHOT-1:0] shot_x;
    logic [COORD_W*NSHOT-1:0] shot_y;
    logic                     fire_ack;
    logic                     cool_busy;

    modport master (
        output gameover, fire, reimux, reimuy, hit,
        input  shot_valid, shot_x, shot_y, fire_ack, cool_busy
    );

    modport slave (
        input  gameover, fire, reimux, reimuy, hit,
        output shot_valid, shot_x, shot_y, fire_ack, cool_busy
    );
endinterface

// File: rtl/reimu_shot_ctrl_shot_slot_alloc.sv
// Find-first-zero over the live mask: reports whether a slot is free and the lowest free index.
// Latency: combinational.
// Backpressure: none; free=0 tells the caller the pool is full.
module shot_slot_alloc
    import reimu_shot_ctrl_pkg::*;
#(
    parameter int NSHOT = 4,
    parameter int IW    = idx_w(NSHOT)
) (
    input  logic [NSHOT-1:0] shot_valid,
    output logic             free,
    output logic [IW-1:0]    k
);

    // Scan from the top down so the last hit, the lowest free index, wins.
    always_comb begin
        free = 1'b0;
        k    = '0;
        for (int i = NSHOT - 1; i >= 0; i--) begin
            if (!shot_valid[i]) begin
                free = 1'b1;
                k    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/reimu_shot_ctrl.sv
// Player-shot scheduler: launches shots into the lowest free slot, moves them up, retires them.
// Latency: one tick; a launch sampled on an edge is visible on the outputs right after it.
// Backpressure: fire is refused (no fire_ack) while cooling down or while every slot is live.
module reimu_shot_ctrl
    import reimu_shot_ctrl_pkg::*;
#(
    parameter int NSHOT      = 4,
    parameter int COOLDOWN   = 6,
    parameter int SHOT_SPEED = 10,
    parameter int SHOT_YOFF  = 10,
    parameter int Y_TOP      = Y_TOP_DEF
) (
    input  logic                clk22,
    input  logic                rst,
    reimu_shot_ctrl_if.slave    bus
);

    localparam int                 IW       = idx_w(NSHOT);
    localparam int                 CW       = idx_w(COOLDOWN + 1);
    localparam logic [COORD_W:0]   RETIRE_Y = (COORD_W + 1)'(Y_TOP + SHOT_SPEED);
    localparam coord_t             SPEED    = coord_t'(SHOT_SPEED);
    localparam coord_t             YOFF     = coord_t'(SHOT_YOFF);
    localparam logic [CW-1:0]      CNT_LOAD = CW'(COOLDOWN);

    cool_state_t              state;
    logic [CW-1:0]            cnt;
    logic                     fire_ack_q;
    logic [NSHOT-1:0]         valid_q;
    coord_t                   sx_q [NSHOT];
    coord_t                   sy_q [NSHOT];
    logic [COORD_W*NSHOT-1:0] sx_flat;
    logic [COORD_W*NSHOT-1:0] sy_flat;

    logic                     slot_free;
    logic [IW-1:0]            slot_k;
    logic                     clear;
    logic                     launch;
    coord_t                   launch_y;

    // Gameover wipes the field exactly like reset does.
    assign clear    = !rst || bus.gameover;
    // Free-slot search looks at the live mask from the start of the tick, so
    // slots retiring this tick are not reusable until the next one.
    assign launch   = bus.fire && (state == READY) && slot_free;
    assign launch_y = (bus.reimuy < YOFF) ? '0 : bus.reimuy - YOFF;

    shot_slot_alloc #(
        .NSHOT (NSHOT),
        .IW    (IW)
    ) u_alloc (
        .shot_valid (valid_q),
        .free       (slot_free),
        .k          (slot_k)
    );

    // Cooldown FSM: a launch arms the counter, which drains one per tick back to READY.
    always_ff @(posedge clk22) begin
        if (clear) begin
            state      <= READY;
            cnt        <= '0;
            fire_ack_q <= 1'b0;
        end else begin
            fire_ack_q <= launch;
            case (state)
                READY: begin
                    if (launch && (COOLDOWN > 0)) begin
                        state <= COOL;
                        cnt   <= CNT_LOAD;
                    end
                end
                COOL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= READY;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    // Slot pool: kill on hit, retire near the top, otherwise move up; then place any new shot.
    always_ff @(posedge clk22) begin
        if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < NSHOT; i++) begin
                sx_q[i] <= '0;
                sy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSHOT; i++) begin
                if (valid_q[i]) begin
                    if (bus.hit[i]) begin
                        valid_q[i] <= 1'b0;
                    end else if ({1'b0, sy_q[i]} < RETIRE_Y) begin
                        valid_q[i] <= 1'b0;
                    end else begin
                        sy_q[i] <= sy_q[i] - SPEED;
                    end
                end
            end
            // The launch slot was free at tick start, so it never collides with a move above.
            if (launch) begin
                valid_q[slot_k] <= 1'b1;
                sx_q[slot_k]    <= bus.reimux;
                sy_q[slot_k]    <= launch_y;
            end
        end
    end

    // Flatten per-slot coordinates onto the packed output buses.
    always_comb begin
        sx_flat = '0;
        sy_flat = '0;
        for (int i = 0; i < NSHOT; i++) begin
            sx_flat[i*COORD_W +: COORD_W] = sx_q[i];
            sy_flat[i*COORD_W +: COORD_W] = sy_q[i];
        end
    end

    assign bus.shot_valid = valid_q;
    assign bus.shot_x     = sx_flat;
    assign bus.shot_y     = sy_flat;
    assign bus.fire_ack   = fire_ack_q;
    assign bus.cool_busy  = (state == COOL);

endmodule

// File: tb/tb_reimu_shot_ctrl.sv
// Self-checking bench for the player-shot scheduler.
// Latency: outputs compared 1 time unit after each rising clk22 edge.
// Backpressure: fire refusal is checked through fire_ack.
module tb_reimu_shot_ctrl;
    import reimu_shot_ctrl_pkg::*;

    localparam int NSHOT    = 4;
    localparam int COOLDOWN = 6;
    localparam int SPEED    = 10;
    localparam int YOFF     = 10;
    localparam int YTOP     = 10;

    logic clk22 = 1'b0;
    logic rst;
    always #5 clk22 = ~clk22;

    reimu_shot_ctrl_if #(.NSHOT(NSHOT)) bus();

    reimu_shot_ctrl #(
        .NSHOT      (NSHOT),
        .COOLDOWN   (COOLDOWN),
        .SHOT_SPEED (SPEED),
        .SHOT_YOFF  (YOFF),
        .Y_TOP      (YTOP)
    ) dut (
        .clk22 (clk22),
        .rst   (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_v;
        logic       go;
        logic       f;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] h;
        logic [3:0] e_vld;
        logic       e_ack;
        logic       e_busy;
        logic [9:0] e_x0;
        logic [9:0] e_y0;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mkv(input logic r, input logic g, input logic f,
                                 input logic [9:0] x, input logic [9:0] y, input logic [3:0] h,
                                 input logic [3:0] ev, input logic ea, input logic eb,
                                 input logic [9:0] ex, input logic [9:0] ey);
        vec_t v;
        v.rst_v = r;  v.go = g;  v.f = f;  v.x = x;  v.y = y;  v.h = h;
        v.e_vld = ev; v.e_ack = ea; v.e_busy = eb; v.e_x0 = ex; v.e_y0 = ey;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic g, input logic f,
                         input logic [9:0] x, input logic [9:0] y, input logic [3:0] h);
        rst          = r;
        bus.gameover = g;
        bus.fire     = f;
        bus.reimux   = x;
        bus.reimuy   = y;
        bus.hit      = h;
        @(posedge clk22);
        #1;
    endtask

    function automatic logic [9:0] sx(input int i);
        return bus.shot_x[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return bus.shot_y[i*10 +: 10];
    endfunction

    // Reference model: slot pool as plain arrays, cooldown as "earliest tick a launch is allowed".
    bit m_live[NSHOT];
    int m_x[NSHOT];
    int m_y[NSHOT];
    int m_tick;
    int m_next_ok;
    bit m_ack;

    task automatic model_step(input bit r, input bit g, input bit f,
                              input int x, input int y, input bit [3:0] h);
        int k;
        k = -1;
        if (!r || g) begin
            for (int i = 0; i < NSHOT; i++) begin
                m_live[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
            end
            m_ack     = 1'b0;
            m_next_ok = 0;
        end else begin
            for (int i = NSHOT - 1; i >= 0; i--) if (!m_live[i]) k = i;
            m_ack = f && (m_tick >= m_next_ok) && (k >= 0);
            for (int i = 0; i < NSHOT; i++) begin
                if (m_live[i]) begin
                    if (h[i])                      m_live[i] = 1'b0;
                    else if (m_y[i] < YTOP + SPEED) m_live[i] = 1'b0;
                    else                           m_y[i] = m_y[i] - SPEED;
                end
            end
            if (m_ack) begin
                m_live[k] = 1'b1;
                m_x[k]    = x;
                m_y[k]    = (y >= YOFF) ? y - YOFF : 0;
                m_next_ok = m_tick + COOLDOWN + 1;
            end
        end
        m_tick++;
    endtask

    initial begin
        logic [3:0]  ev;
        logic [39:0] ex, ey;
        bit          rr, gg, ff;
        int          rx, ry;
        bit [3:0]    hh;

        rst = 1'b0; bus.gameover = 1'b0; bus.fire = 1'b0;
        bus.reimux = '0; bus.reimuy = '0; bus.hit = '0;

        // Reset held with fire, then auto-fire at x=220 y=360 for ticks 0..21.
        tbl[0] = mkv(1'b0, 1'b0, 1'b1, 10'd220, 10'd360, 4'd0, 4'd0, 1'b0, 1'b0, 10'd0, 10'd0);
        tbl[1] = tbl[0];
        for (int t = 0; t < 22; t++) begin
            tbl[t+2] = mkv(1'b1, 1'b0, 1'b1, 10'd220, 10'd360, 4'd0,
                           4'((1 << (t / 7 + 1)) - 1), (t % 7) == 0, (t % 7) != 6,
                           10'd220, 10'(350 - 10 * t));
        end
        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].rst_v, tbl[i].go, tbl[i].f, tbl[i].x, tbl[i].y, tbl[i].h);
            chk($sformatf("vec%0d_valid", i), bus.shot_valid, tbl[i].e_vld);
            chk($sformatf("vec%0d_ack", i),   bus.fire_ack,   tbl[i].e_ack);
            chk($sformatf("vec%0d_busy", i),  bus.cool_busy,  tbl[i].e_busy);
            chk($sformatf("vec%0d_x0", i),    sx(0),          tbl[i].e_x0);
            chk($sformatf("vec%0d_y0", i),    sy(0),          tbl[i].e_y0);
        end

        // Pool full with fire held: slot0 creeps to the top (20 -> 10 -> retired).
        for (int t = 22; t <= 35; t++) begin
            apply(1'b1, 1'b0, 1'b1, 10'd220, 10'd360, 4'd0);
            chk("pool_no_ack", bus.fire_ack, 1'b0);
            if (t >= 28) chk("pool_counter_idle", bus.cool_busy, 1'b0);
            if (t < 35)  chk("pool_full_valid", bus.shot_valid, 4'hf);
            if (t == 34) chk("retire_y_10", sy(0), 10'd10);
            if (t == 35) begin
                chk("retire_valid", bus.shot_valid, 4'he);
                chk("retire_y_held", sy(0), 10'd10);
            end
        end
        apply(1'b1, 1'b0, 1'b1, 10'd220, 10'd360, 4'd0);
        chk("refill_ack", bus.fire_ack, 1'b1);
        chk("refill_valid", bus.shot_valid, 4'hf);
        chk("refill_y0", sy(0), 10'd350);
        chk("refill_busy", bus.cool_busy, 1'b1);

        // Gameover mid-cooldown clears everything; launch follows at once.
        apply(1'b1, 1'b1, 1'b1, 10'd220, 10'd360, 4'd0);
        chk("go_valid", bus.shot_valid, 4'd0);
        chk("go_ack", bus.fire_ack, 1'b0);
        chk("go_busy", bus.cool_busy, 1'b0);
        chk("go_x", bus.shot_x, 40'd0);
        chk("go_y", bus.shot_y, 40'd0);
        apply(1'b1, 1'b0, 1'b1, 10'd220, 10'd360, 4'd0);
        chk("post_go_ack", bus.fire_ack, 1'b1);
        chk("post_go_valid", bus.shot_valid, 4'd1);

        // Hit on slot1 at y=100 while firing: new shot goes to slot2, slot1 reused later.
        apply(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 4'd0);
        apply(1'b1, 1'b0, 1'b1, 10'd220, 10'd360, 4'd0);
        chk("hit_setup_valid", bus.shot_valid, 4'd1);
        for (int j = 0; j < 6; j++) apply(1'b1, 1'b0, 1'b0, 10'd220, 10'd360, 4'd0);
        apply(1'b1, 1'b0, 1'b1, 10'd300, 10'd170, 4'd0);
        chk("hit_s1_ack", bus.fire_ack, 1'b1);
        chk("hit_s1_valid", bus.shot_valid, 4'd3);
        chk("hit_s1_x", sx(1), 10'd300);
        chk("hit_s1_y", sy(1), 10'd160);
        for (int j = 0; j < 6; j++) apply(1'b1, 1'b0, 1'b0, 10'd300, 10'd170, 4'd0);
        chk("hit_s1_y100", sy(1), 10'd100);
        apply(1'b1, 1'b0, 1'b1, 10'd300, 10'd170, 4'b0010);
        chk("hit_ack", bus.fire_ack, 1'b1);
        chk("hit_valid", bus.shot_valid, 4'b0101);
        chk("hit_y_held", sy(1), 10'd100);
        chk("hit_s2_y", sy(2), 10'd160);
        for (int j = 0; j < 6; j++) begin
            apply(1'b1, 1'b0, 1'b1, 10'd300, 10'd170, 4'd0);
            chk("hit_cool_no_ack", bus.fire_ack, 1'b0);
        end
        apply(1'b1, 1'b0, 1'b1, 10'd300, 10'd170, 4'd0);
        chk("reuse_ack", bus.fire_ack, 1'b1);
        chk("reuse_valid", bus.shot_valid, 4'b0111);
        chk("reuse_y", sy(1), 10'd160);

        // Launch at y=30: 20 stays live, 10 stays live, then retired; saturation at y<YOFF.
        apply(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 4'd0);
        apply(1'b1, 1'b0, 1'b1, 10'd100, 10'd40, 4'd0);
        chk("top_y30", sy(0), 10'd30);
        apply(1'b1, 1'b0, 1'b0, 10'd100, 10'd40, 4'd0);
        chk("top_y20", sy(0), 10'd20);
        chk("top_y20_valid", bus.shot_valid, 4'd1);
        apply(1'b1, 1'b0, 1'b0, 10'd100, 10'd40, 4'd0);
        chk("top_y10", sy(0), 10'd10);
        chk("top_y10_valid", bus.shot_valid, 4'd1);
        apply(1'b1, 1'b0, 1'b0, 10'd100, 10'd40, 4'd0);
        chk("top_retired", bus.shot_valid, 4'd0);
        for (int j = 0; j < 3; j++) apply(1'b1, 1'b0, 1'b0, 10'd100, 10'd40, 4'd0);
        apply(1'b1, 1'b0, 1'b1, 10'd100, 10'd5, 4'd0);
        chk("sat_ack", bus.fire_ack, 1'b1);
        chk("sat_y0", sy(0), 10'd0);
        apply(1'b1, 1'b0, 1'b0, 10'd100, 10'd5, 4'd0);
        chk("sat_retired", bus.shot_valid, 4'd0);

        // Randomized traffic against the reference model.
        m_tick = 0;
        model_step(1'b0, 1'b0, 1'b0, 0, 0, 4'd0);
        apply(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 4'd0);
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom % 97) != 0;
            gg = ($urandom % 80) == 0;
            ff = ($urandom % 4) != 0;
            rx = int'($urandom % 1024);
            ry = (($urandom % 4) == 0) ? int'($urandom % 20) : int'($urandom % 1024);
            hh = (($urandom % 6) == 0) ? 4'($urandom) : 4'd0;
            model_step(rr, gg, ff, rx, ry, hh);
            apply(rr, gg, ff, 10'(rx), 10'(ry), hh);
            ev = '0; ex = '0; ey = '0;
            for (int i = 0; i < NSHOT; i++) begin
                ev[i]          = m_live[i];
                ex[i*10 +: 10] = 10'(m_x[i]);
                ey[i*10 +: 10] = 10'(m_y[i]);
            end
            chk($sformatf("rnd%0d_valid", n), bus.shot_valid, ev);
            chk($sformatf("rnd%0d_x", n),     bus.shot_x,     ex);
            chk($sformatf("rnd%0d_y", n),     bus.shot_y,     ey);
            chk($sformatf("rnd%0d_ack", n),   bus.fire_ack,   m_ack);
            chk($sformatf("rnd%0d_busy", n),  bus.cool_busy,  m_tick < m_next_ok);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
